olive_std_core_boot_arbiter: RTL and testbench

Round-robin arbiter that shares the second (s2) port of the 512×32 boot RAM between two Avalon-MM masters, typically the boot loader DMA and the debug/host bridge. It serialises accesses onto the single RAM port and tracks the RAM's fixed read latency. It returns read data with `readdatavalid` to the master that issued the read. It sits between the interconnect and the boot RAM's `address2/byteenable2/chipselect2/write2/writedata2/readdata2` pins.

---
 rtl/olive_boot_arb_pkg.sv | 9 +
 rtl/olive_boot_arb_rr2.sv | 17 +
 rtl/olive_std_core_boot_arbiter.sv | 81 ++++++++
 tb/tb_olive_std_core_boot_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/olive_boot_arb_pkg.sv
// olive_boot_arb_pkg: shared defaults and read-tag type for the boot RAM arbiter
package olive_boot_arb_pkg;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;
    typedef struct packed {
        logic valid;
        logic owner;
    } rd_tag_t;
endpackage

// File: rtl/olive_boot_arb_rr2.sv
// olive_boot_arb_rr2: two-way round-robin grant with last_grant register
module olive_boot_arb_rr2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);
    logic last_grant;
    always_ff @(posedge clk) begin
        if (reset) last_grant <= 1'b1;
        else if (|grant) last_grant <= grant[1];
    end
    always_comb begin
        grant[0] = ~reset & req[0] & (~req[1] | last_grant);
        grant[1] = ~reset & req[1] & (~req[0] | ~last_grant);
    end
endmodule

// File: rtl/olive_std_core_boot_arbiter.sv
// olive_std_core_boot_arbiter: round-robin share of the boot RAM s2 port between two Avalon-MM masters
module olive_std_core_boot_arbiter
    import olive_boot_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int READ_PIPE  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   m0_address,
    input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
    input  logic                    m0_read,
    input  logic                    m0_write,
    input  logic [DATA_WIDTH-1:0]   m0_writedata,
    output logic                    m0_waitrequest,
    output logic [DATA_WIDTH-1:0]   m0_readdata,
    output logic                    m0_readdatavalid,
    input  logic [ADDR_WIDTH-1:0]   m1_address,
    input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
    input  logic                    m1_read,
    input  logic                    m1_write,
    input  logic [DATA_WIDTH-1:0]   m1_writedata,
    output logic                    m1_waitrequest,
    output logic [DATA_WIDTH-1:0]   m1_readdata,
    output logic                    m1_readdatavalid,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [DATA_WIDTH/8-1:0] ram_byteenable,
    output logic                    ram_chipselect,
    output logic                    ram_write,
    output logic [DATA_WIDTH-1:0]   ram_writedata,
    input  logic [DATA_WIDTH-1:0]   ram_readdata,
    output logic                    ram_clken
);
    logic [1:0] grant;
    logic sel, wr;
    rd_tag_t tag_in;
    rd_tag_t [READ_PIPE:0] tag_q;
    logic [DATA_WIDTH-1:0] rdata;
    olive_boot_arb_rr2 u_rr2 (
        .clk   (clk),
        .reset (reset),
        .req   ({m1_read | m1_write, m0_read | m0_write}),
        .grant (grant)
    );
    always_comb begin
        sel = grant[1];
        wr = sel ? m1_write : m0_write;
        ram_chipselect = |grant;
        ram_write = ram_chipselect & wr;
        ram_address = sel ? m1_address : m0_address;
        ram_byteenable = wr ? (sel ? m1_byteenable : m0_byteenable) : '1;
        ram_writedata = sel ? m1_writedata : m0_writedata;
        tag_in.valid = ram_chipselect & ~wr;
        tag_in.owner = sel;
    end
    assign ram_clken = 1'b1;
    assign m0_waitrequest = reset | ~grant[0];
    assign m1_waitrequest = reset | ~grant[1];
    // tag shift register matches the RAM latency plus the optional data register
    always_ff @(posedge clk) begin
        if (reset) tag_q <= '0;
        else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= READ_PIPE; i++) tag_q[i] <= tag_q[i-1];
        end
    end
    generate
        if (READ_PIPE != 0) begin : g_pipe
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk) rdata_q <= ram_readdata;
            assign rdata = rdata_q;
        end else begin : g_pass
            assign rdata = ram_readdata;
        end
    endgenerate
    assign m0_readdata = rdata;
    assign m1_readdata = rdata;
    assign m0_readdatavalid = ~reset & tag_q[READ_PIPE].valid & ~tag_q[READ_PIPE].owner;
    assign m1_readdatavalid = ~reset & tag_q[READ_PIPE].valid & tag_q[READ_PIPE].owner;
endmodule

// File: tb/tb_olive_std_core_boot_arbiter.sv
// tb_olive_std_core_boot_arbiter: random and directed checks of both READ_PIPE variants against a transaction model
module tb_olive_std_core_boot_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
    logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;

    logic w0 [2], w1 [2], v0 [2], v1 [2], cs [2], we [2], ck [2];
    logic [DW-1:0] rd0 [2], rd1 [2], ram_wd [2], ram_rd [2];
    logic [AW-1:0] ram_a [2];
    logic [BW-1:0] ram_be [2];

    function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
        return ({23'h0, a} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction
    function automatic logic [DW-1:0] bmask(input logic [BW-1:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    olive_std_core_boot_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE(0)) u_p0 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(w0[0]), .m0_readdata(rd0[0]), .m0_readdatavalid(v0[0]),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(w1[0]), .m1_readdata(rd1[0]), .m1_readdatavalid(v1[0]),
        .ram_address(ram_a[0]), .ram_byteenable(ram_be[0]), .ram_chipselect(cs[0]), .ram_write(we[0]),
        .ram_writedata(ram_wd[0]), .ram_readdata(ram_rd[0]), .ram_clken(ck[0])
    );
    olive_std_core_boot_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_PIPE(1)) u_p1 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(w0[1]), .m0_readdata(rd0[1]), .m0_readdatavalid(v0[1]),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(w1[1]), .m1_readdata(rd1[1]), .m1_readdatavalid(v1[1]),
        .ram_address(ram_a[1]), .ram_byteenable(ram_be[1]), .ram_chipselect(cs[1]), .ram_write(we[1]),
        .ram_writedata(ram_wd[1]), .ram_readdata(ram_rd[1]), .ram_clken(ck[1])
    );

    // RAM port models; stored words are XORed with seed() so unwritten words read as seed(addr)
    logic [DW-1:0] mem_p0 [512] = '{default: '0};
    logic [DW-1:0] mem_p1 [512] = '{default: '0};
    always @(posedge clk) begin
        if (cs[0]) begin
            if (we[0]) mem_p0[ram_a[0]] <= (mem_p0[ram_a[0]] & ~bmask(ram_be[0])) | ((ram_wd[0] ^ seed(ram_a[0])) & bmask(ram_be[0]));
            else ram_rd[0] <= mem_p0[ram_a[0]] ^ seed(ram_a[0]);
        end
    end
    always @(posedge clk) begin
        if (cs[1]) begin
            if (we[1]) mem_p1[ram_a[1]] <= (mem_p1[ram_a[1]] & ~bmask(ram_be[1])) | ((ram_wd[1] ^ seed(ram_a[1])) & bmask(ram_be[1]));
            else ram_rd[1] <= mem_p1[ram_a[1]] ^ seed(ram_a[1]);
        end
    end

    typedef struct {
        int due;
        logic own;
        logic [DW-1:0] d;
    } ret_t;

    int errs = 0;
    int checks = 0;
    int cyc = 0;
    logic last_m1 = 1'b1;
    logic [DW-1:0] ref_mem [512];
    ret_t rq0 [$];
    ret_t rq1 [$];

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cmp_ret(input int p, input logic ev, input logic eo, input logic [DW-1:0] ed);
        check($sformatf("pipe%0d m0_readdatavalid", p), {31'h0, v0[p]}, {31'h0, ev & ~eo});
        check($sformatf("pipe%0d m1_readdatavalid", p), {31'h0, v1[p]}, {31'h0, ev & eo});
        if (ev) begin
            check($sformatf("pipe%0d m0_readdata", p), rd0[p], ed);
            check($sformatf("pipe%0d m1_readdata", p), rd1[p], ed);
        end
    endtask

    task automatic tick();
        logic q0, q1, g0, g1, own, isw, ev;
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] wd;
        ret_t r;
        #1;
        q0 = m0_read | m0_write;
        q1 = m1_read | m1_write;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!reset) begin
            if (q0 && q1) begin
                g0 = last_m1;
                g1 = !last_m1;
            end else begin
                g0 = q0;
                g1 = q1;
            end
        end
        own = g1;
        isw = own ? m1_write : m0_write;
        a = own ? m1_address : m0_address;
        be = own ? m1_byteenable : m0_byteenable;
        wd = own ? m1_writedata : m0_writedata;
        if (reset) begin
            rq0.delete();
            rq1.delete();
        end
        for (int p = 0; p < 2; p++) begin
            check($sformatf("pipe%0d m0_waitrequest", p), {31'h0, w0[p]}, {31'h0, !g0});
            check($sformatf("pipe%0d m1_waitrequest", p), {31'h0, w1[p]}, {31'h0, !g1});
            check($sformatf("pipe%0d ram_chipselect", p), {31'h0, cs[p]}, {31'h0, g0 | g1});
            check($sformatf("pipe%0d ram_write", p), {31'h0, we[p]}, {31'h0, (g0 | g1) & isw});
            check($sformatf("pipe%0d ram_clken", p), {31'h0, ck[p]}, 32'h1);
            if (g0 | g1) begin
                check($sformatf("pipe%0d ram_address", p), {23'h0, ram_a[p]}, {23'h0, a});
                check($sformatf("pipe%0d ram_byteenable", p), {28'h0, ram_be[p]}, {28'h0, isw ? be : 4'hF});
                if (isw) check($sformatf("pipe%0d ram_writedata", p), ram_wd[p], wd);
            end
        end
        ev = 1'b0;
        r = '{due: 0, own: 1'b0, d: '0};
        if (rq0.size() > 0 && rq0[0].due == cyc) begin
            r = rq0.pop_front();
            ev = 1'b1;
        end
        cmp_ret(0, ev, r.own, r.d);
        ev = 1'b0;
        r = '{due: 0, own: 1'b0, d: '0};
        if (rq1.size() > 0 && rq1[0].due == cyc) begin
            r = rq1.pop_front();
            ev = 1'b1;
        end
        cmp_ret(1, ev, r.own, r.d);
        if (reset) last_m1 = 1'b1;
        else if (g0 | g1) begin
            if (isw) ref_mem[a] = (ref_mem[a] & ~bmask(be)) | (wd & bmask(be));
            else begin
                rq0.push_back('{due: cyc + 1, own: own, d: ref_mem[a]});
                rq1.push_back('{due: cyc + 2, own: own, d: ref_mem[a]});
            end
            last_m1 = own;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic set0(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        m0_read = r; m0_write = w; m0_address = a; m0_byteenable = b; m0_writedata = d;
    endtask
    task automatic set1(input logic r, input logic w, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        m1_read = r; m1_write = w; m1_address = a; m1_byteenable = b; m1_writedata = d;
    endtask
    task automatic idle(input int n);
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = seed(AW'(i));
        @(negedge clk);
        reset = 1'b1;
        set0(1, 0, 9'h010, 4'h0, 0);
        set1(0, 1, 9'h020, 4'hF, 32'h12345678);
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b0;
        set1(0, 0, 0, 0, 0);
        set0(0, 1, 9'h005, 4'hF, 32'hDEADBEEF);
        tick();
        set0(1, 0, 9'h005, 4'h3, 0);
        tick();
        idle(3);
        // m1 write then m0 read of the same word on the next cycle
        set1(0, 1, 9'h030, 4'hF, 32'hCAFEF00D);
        tick();
        set1(0, 0, 0, 0, 0);
        set0(1, 0, 9'h030, 4'hF, 0);
        tick();
        set0(0, 0, 0, 0, 0);
        set1(1, 0, 9'h020, 4'hF, 0);
        tick();
        set0(1, 0, 9'h010, 4'hF, 0);
        for (int i = 0; i < 6; i++) tick();
        idle(3);
        set1(0, 1, 9'h1FF, 4'hF, 32'h11223344);
        tick();
        set1(1, 1, 9'h1FF, 4'h5, 32'hAABBCCDD);
        tick();
        set1(1, 0, 9'h1FF, 4'h0, 0);
        tick();
        idle(3);
        set1(1, 0, 9'h005, 4'hF, 0); tick();
        set1(1, 0, 9'h030, 4'hF, 0); tick();
        set1(1, 0, 9'h1FF, 4'hF, 0); tick();
        set1(1, 0, 9'h010, 4'hF, 0); tick();
        idle(3);
        // reset the cycle after a read is accepted; both requesting afterwards
        set0(1, 0, 9'h005, 4'hF, 0);
        tick();
        reset = 1'b1;
        set0(0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        set0(1, 0, 9'h1FF, 4'hF, 0);
        set1(1, 0, 9'h030, 4'hF, 0);
        tick();
        tick();
        idle(3);
        for (int i = 0; i < 300; i++) begin
            int op0, op1;
            op0 = int'($urandom_range(0, 3));
            op1 = int'($urandom_range(0, 3));
            set0(op0[0], op0[1], ($urandom_range(0, 9) == 0) ? 9'h1FF : AW'($urandom_range(0, 7)), BW'($urandom), $urandom);
            set1(op1[0], op1[1], ($urandom_range(0, 9) == 0) ? 9'h1FF : AW'($urandom_range(0, 7)), BW'($urandom), $urandom);
            reset = ($urandom_range(0, 39) == 0);
            tick();
        end
        reset = 1'b0;
        idle(4);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
